run_sequencer: RTL

Run controller for the Pebble core. It holds the core in reset while idle and releases it on a start request. It then gates execution, counts run cycles and watches for the halt flag or a cycle-limit timeout. It also owns the data-memory address/data mux, so a host (bench or loader) can preload operands and read results through a granted handshake whenever the core is not running.

---
 rtl/run_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/run_sequencer.sv
// Run controller for the Pebble core: sequences core reset/run, counts run
// cycles, detects halt or timeout, and arbitrates data memory between core and host.
module run_sequencer #(
  parameter int          RST_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        core_done,
  input  logic        core_dm_we,
  input  logic [7:0]  core_dm_addr,
  input  logic [7:0]  core_dm_wdata,
  input  logic [7:0]  dm_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic        core_reset,
  output logic        core_run,
  output logic        dm_we,
  output logic [7:0]  dm_addr,
  output logic [7:0]  dm_wdata,
  output logic        host_gnt,
  output logic [7:0]  host_rdata,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, RST, RUN, HALT} state_t;

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t        state;
  logic [CW-1:0] rst_cnt;
  logic          host_phase;
  logic          grant;

  assign host_phase = (state == IDLE) || (state == HALT);
  // A start in the same cycle takes priority, so the host access (and its write) is deferred.
  assign grant      = host_phase & host_req & ~host_gnt & ~start;

  assign core_reset = (state == IDLE) || (state == RST);
  assign core_run   = (state == RUN);

  assign dm_addr  = core_run ? core_dm_addr  : host_addr;
  assign dm_wdata = core_run ? core_dm_wdata : host_wdata;
  assign dm_we    = core_run ? core_dm_we    : (grant & host_we);

  // NOTE: every register here is updated with non-blocking assignments so all
  // next-state terms see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      host_gnt    <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_gnt <= grant;
      if (grant) host_rdata <= dm_rdata;

      case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= RST;
            rst_cnt     <= CW'(RST_CYCLES - 1);
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
          end
        end
        RST: begin
          if (rst_cnt == '0) state <= RUN;
          else               rst_cnt <= rst_cnt - CW'(1);
        end
        RUN: begin
          if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
          // A normal halt outranks a timeout landing on the same cycle.
          if (core_done) begin
            state <= HALT;
            done  <= 1'b1;
          end else if (cycle_count == MAX_CYCLES - 16'd1) begin
            state   <= HALT;
            timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
